// File: rtl/spi_byte_reg_decoder_pkg.sv
// Shared definitions for the SPI byte register decoder: FSM states and byte constants.
// No logic; types and constants only.
// Used by the decoder top and its register bank.
package spi_byte_reg_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    // Command byte bit selecting write (1) or read (0).
    localparam int CMD_WR_BIT = 7;

    // Byte presented to the SPI slave whenever no readback data is pending.
    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: REG_COUNT x 8-bit registers, one synchronous write port, combinational read.
// Latency: write lands at the clock edge; read data and range flag are combinational on addr.
// No backpressure: a write is accepted every cycle wr_en is high (dropped if addr out of range).
module spi_reg_bank #(
    parameter int         REG_COUNT = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    output logic                   in_range,
    output logic [REG_COUNT*8-1:0] regs_flat
);

    logic [7:0] regs [REG_COUNT];

    // Addresses at or above REG_COUNT have no backing register.
    assign in_range = (int'(addr) < REG_COUNT);

    // Register storage; out-of-range writes match no register and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= RST_VAL;
            end
        end else if (wr_en && in_range) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (addr == ADDR_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Read mux; unmatched (out-of-range) addresses read back as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    // Flatten the bank so board logic can see every register at once.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_flat[8*i +: 8] = regs[i];
        end
    end

endmodule

// File: rtl/spi_byte_reg_decoder.sv
// Parses SPI slave bytes into command frames (cmd + data) and reads/writes a register bank.
// Latency: rx_valid in cycle n updates registers / tx_byte / wr_strobe at the edge ending cycle n.
// No backpressure: every rx_valid byte is consumed; dropping ss_active aborts the frame at once.
module spi_byte_reg_decoder
    import spi_byte_reg_decoder_pkg::*;
#(
    parameter int         REG_COUNT = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic                   CLOCK_Y2,
    input  logic                   RESET,
    input  logic                   ss_active,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    output logic [7:0]             tx_byte,
    output logic                   tx_load,
    output logic                   wr_strobe,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [REG_COUNT*8-1:0] regs_flat,
    output logic                   bad_addr,
    output logic                   LED1
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   bank_addr;
    logic [7:0]          rd_data;
    logic                in_range;
    logic                bank_wr_en;

    // While the command byte arrives the bank is addressed straight from it, so a read
    // can fetch its first byte in the same cycle the command is received.
    assign bank_addr  = (state == ST_CMD) ? rx_byte[ADDR_W-1:0] : addr;
    assign bank_wr_en = ss_active && rx_valid && (state == ST_WDATA);

    spi_reg_bank #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W),
        .RST_VAL   (RST_VAL)
    ) u_bank (
        .clk       (CLOCK_Y2),
        .reset     (RESET),
        .wr_en     (bank_wr_en),
        .addr      (bank_addr),
        .wr_data   (rx_byte),
        .rd_data   (rd_data),
        .in_range  (in_range),
        .regs_flat (regs_flat)
    );

    assign LED1 = regs_flat[0];

    // State register.
    always_ff @(posedge CLOCK_Y2) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: deselect wins everywhere; the command byte picks the frame direction.
    always_comb begin
        state_nxt = state;
        if (!ss_active) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_CMD;
                ST_CMD:   if (rx_valid) state_nxt = rx_byte[CMD_WR_BIT] ? ST_WDATA : ST_RDATA;
                default:  state_nxt = state;
            endcase
        end
    end

    // Address counter, transmit path, write strobe and sticky out-of-range flag.
    always_ff @(posedge CLOCK_Y2) begin
        if (RESET) begin
            addr      <= '0;
            tx_byte   <= TX_IDLE_BYTE;
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            bad_addr  <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            if (!ss_active) begin
                tx_byte <= TX_IDLE_BYTE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_byte <= TX_IDLE_BYTE;
                        tx_load <= 1'b1;
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            if (rx_byte[CMD_WR_BIT]) begin
                                addr <= bank_addr;
                            end else begin
                                tx_byte <= rd_data;
                                tx_load <= 1'b1;
                                addr    <= bank_addr + 1'b1;
                                if (!in_range) bad_addr <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rx_valid) begin
                            if (in_range) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                            end else begin
                                bad_addr <= 1'b1;
                            end
                            addr <= addr + 1'b1;
                        end
                    end
                    default: begin
                        if (rx_valid) begin
                            tx_byte <= rd_data;
                            tx_load <= 1'b1;
                            addr    <= addr + 1'b1;
                            if (!in_range) bad_addr <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_reg_decoder.sv
// Bench: two decoders (8 and 6 registers) driven by the same byte stream, checked every
// cycle against a frame-level model, plus hand-computed checks at key points.
module tb_spi_byte_reg_decoder;

    logic       clk = 1'b0;
    logic       rst, ss, rv;
    logic [7:0] rb;

    logic [7:0]  tx8, tx6;
    logic        ld8, ld6, stb8, stb6, bad8, bad6, led8, led6;
    logic [2:0]  wa8, wa6;
    logic [63:0] rf8;
    logic [47:0] rf6;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_byte_reg_decoder #(.REG_COUNT(8), .ADDR_W(3), .RST_VAL(8'h00)) dut8 (
        .CLOCK_Y2(clk), .RESET(rst), .ss_active(ss), .rx_valid(rv), .rx_byte(rb),
        .tx_byte(tx8), .tx_load(ld8), .wr_strobe(stb8), .wr_addr(wa8),
        .regs_flat(rf8), .bad_addr(bad8), .LED1(led8)
    );

    spi_byte_reg_decoder #(.REG_COUNT(6), .ADDR_W(3), .RST_VAL(8'h00)) dut6 (
        .CLOCK_Y2(clk), .RESET(rst), .ss_active(ss), .rx_valid(rv), .rx_byte(rb),
        .tx_byte(tx6), .tx_load(ld6), .wr_strobe(stb6), .wr_addr(wa6),
        .regs_flat(rf6), .bad_addr(bad6), .LED1(led6)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Each frame: first byte after selection is the command, later bytes are data (write)
    // or dummies that each pull the next register (read). Registers beyond the count
    // do not exist: writes vanish, reads give 0, and the error flag sticks.
    int         rc [2] = '{8, 6};
    logic [7:0] m_regs [2][8];
    bit         m_sel [2];
    int         m_nb [2];
    bit         m_wr [2];
    int         m_a [2];
    logic [7:0] m_tx [2];
    bit         m_load [2];
    bit         m_stb [2];
    int         m_waddr [2];
    bit         m_bad [2];
    bit         mvalid = 0;

    function automatic logic [63:0] m_flat(input int k);
        logic [63:0] f = '0;
        for (int i = 0; i < rc[k]; i++) f[8*i +: 8] = m_regs[k][i];
        return f;
    endfunction

    task automatic m_read(input int k);
        m_tx[k]   = (m_a[k] < rc[k]) ? m_regs[k][m_a[k]] : 8'h00;
        m_load[k] = 1;
        if (m_a[k] >= rc[k]) m_bad[k] = 1;
        m_a[k] = (m_a[k] + 1) % 8;
    endtask

    task automatic m_step(input int k);
        m_load[k] = 0;
        m_stb[k]  = 0;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[k][i] = 8'h00;
            m_sel[k] = 0; m_nb[k] = 0; m_a[k] = 0; m_tx[k] = 8'h00;
            m_waddr[k] = 0; m_bad[k] = 0;
        end else if (!ss) begin
            m_sel[k] = 0;
            m_tx[k]  = 8'h00;
        end else if (!m_sel[k]) begin
            m_sel[k]  = 1;
            m_nb[k]   = 0;
            m_tx[k]   = 8'h00;
            m_load[k] = 1;
        end else if (rv) begin
            if (m_nb[k] == 0) begin
                m_wr[k] = rb[7];
                m_a[k]  = int'(rb[2:0]);
                if (!m_wr[k]) m_read(k);
            end else if (m_wr[k]) begin
                if (m_a[k] < rc[k]) begin
                    m_regs[k][m_a[k]] = rb;
                    m_stb[k]   = 1;
                    m_waddr[k] = m_a[k];
                end else begin
                    m_bad[k] = 1;
                end
                m_a[k] = (m_a[k] + 1) % 8;
            end else begin
                m_read(k);
            end
            m_nb[k]++;
        end
    endtask

    // Compare outputs of the last edge, then advance the model with the inputs the next edge samples.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("dut8.tx_byte",   64'(tx8),  64'(m_tx[0]));
            chk("dut8.tx_load",   64'(ld8),  64'(m_load[0]));
            chk("dut8.wr_strobe", 64'(stb8), 64'(m_stb[0]));
            chk("dut8.wr_addr",   64'(wa8),  64'(m_waddr[0]));
            chk("dut8.regs_flat", rf8,       m_flat(0));
            chk("dut8.bad_addr",  64'(bad8), 64'(m_bad[0]));
            chk("dut8.LED1",      64'(led8), 64'(m_regs[0][0][0]));
            chk("dut6.tx_byte",   64'(tx6),  64'(m_tx[1]));
            chk("dut6.tx_load",   64'(ld6),  64'(m_load[1]));
            chk("dut6.wr_strobe", 64'(stb6), 64'(m_stb[1]));
            chk("dut6.wr_addr",   64'(wa6),  64'(m_waddr[1]));
            chk("dut6.regs_flat", 64'(rf6),  m_flat(1));
            chk("dut6.bad_addr",  64'(bad6), 64'(m_bad[1]));
            chk("dut6.LED1",      64'(led6), 64'(m_regs[1][0][0]));
        end
        m_step(0);
        m_step(1);
        if (rst) mvalid = 1;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic v, input logic [7:0] b);
        ss = s; rv = v; rb = b;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        cyc(1'b1, 1'b1, b);
        if (gap) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic end_frame();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; ss = 1'b0; rv = 1'b0; rb = 8'h00;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("reset regs8", rf8, 64'h0);
        chk("reset tx8", 64'(tx8), 64'h0);
        chk("reset bad8", 64'(bad8), 64'h0);
        rst = 1'b0;
        end_frame();

        // Write frame 81 A5 3C: mix of spaced and back-to-back bytes.
        start_frame();
        send(8'h81, 1); send(8'hA5, 0); send(8'h3C, 1);
        chk("t2 reg1", 64'(rf8[15:8]), 64'hA5);
        chk("t2 reg2", 64'(rf8[23:16]), 64'h3C);
        chk("t2 wr_addr", 64'(wa8), 64'h2);
        end_frame();

        // Write reg0=01, then read from 0 with two back-to-back dummies.
        start_frame();
        send(8'h80, 0); send(8'h01, 1);
        end_frame();
        chk("t3 LED1", 64'(led8), 64'h1);
        start_frame();
        send(8'h00, 0);
        chk("t3 rd0", 64'(tx8), 64'h01);
        send(8'hAA, 0);
        chk("t3 rd1", 64'(tx8), 64'hA5);
        send(8'hBB, 0);
        chk("t3 rd2", 64'(tx8), 64'h3C);
        end_frame();

        // Register 6: exists in dut8, out of range in dut6.
        start_frame();
        send(8'h86, 0); send(8'hFF, 1);
        chk("t5 bad6", 64'(bad6), 64'h1);
        chk("t5 bad8", 64'(bad8), 64'h0);
        chk("t5 reg6", 64'(rf8[55:48]), 64'hFF);
        end_frame();
        start_frame();
        send(8'h06, 1);
        chk("t5 rd6 dut6", 64'(tx6), 64'h00);
        chk("t5 rd6 dut8", 64'(tx8), 64'hFF);
        end_frame();

        // Write across the address wrap 7 -> 0.
        start_frame();
        send(8'h87, 0); send(8'h11, 0); send(8'h22, 1);
        chk("t4 reg7", 64'(rf8[63:56]), 64'h11);
        chk("t4 reg0", 64'(rf8[7:0]), 64'h22);
        chk("t4 LED1", 64'(led8), 64'h0);
        end_frame();

        // Deselect coinciding with a data byte drops it.
        start_frame();
        send(8'h81, 0); send(8'h12, 0);
        cyc(1'b0, 1'b1, 8'h55);
        chk("t6 reg1", 64'(rf8[15:8]), 64'h12);
        chk("t6 reg2", 64'(rf8[23:16]), 64'h3C);
        end_frame();

        // Reset in the middle of a write frame, with a byte arriving.
        start_frame();
        send(8'h81, 0); send(8'h77, 0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'h99);
        chk("t1 regs", rf8, 64'h0);
        chk("t1 strobe", 64'(stb8), 64'h0);
        chk("t1 LED1", 64'(led8), 64'h0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        chk("t1 idle->cmd load", 64'(ld8), 64'h1);
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
